// File: rtl/ts_tx_arbiter_if.sv
// Byte stream from the timestamp arbiter to the UART transmitter.
// A byte moves on a clock edge where tx_valid and tx_ready are both high.
interface ts_tx_arbiter_if;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;

  modport master (
    output tx_data,
    output tx_valid,
    input  tx_ready
  );

  modport slave (
    input  tx_data,
    input  tx_valid,
    output tx_ready
  );
endinterface

// File: rtl/ts_tx_arbiter.sv
// Round-robin arbiter that serialises per-channel timestamps into framed
// byte sequences ({4'hA, ch} header, then timestamp MSB first) for the UART.
module ts_tx_arbiter #(
  parameter int NCH       = 4,
  parameter int TS_WIDTH  = 32,
  parameter int CNT_WIDTH = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      enable,
  input  logic [NCH-1:0]            req,
  input  logic [NCH*TS_WIDTH-1:0]   ts_data,
  output logic [NCH-1:0]            ack,
  ts_tx_arbiter_if.master           tx,
  output logic                      busy,
  output logic [CNT_WIDTH-1:0]      frame_count
);

  localparam int NBYTES = TS_WIDTH / 8;
  localparam int CH_W   = $clog2(NCH);
  localparam int BC_W   = (NBYTES > 1) ? $clog2(NBYTES) : 1;

  typedef enum logic [1:0] {
    IDLE,
    HDR,
    DATA
  } state_t;

  state_t                 state_q;
  logic [CH_W-1:0]        last_grant_q;
  logic [TS_WIDTH-1:0]    shreg_q;
  logic [BC_W-1:0]        byte_cnt_q;
  logic [7:0]             tx_data_q;
  logic                   tx_valid_q;
  logic [NCH-1:0]         ack_q;
  logic [CNT_WIDTH-1:0]   frame_count_q;

  logic [TS_WIDTH-1:0]    ts_arr [NCH];
  logic [CH_W-1:0]        grant_idx_d;
  logic                   grant_vld_d;
  logic [3:0]             hdr_ch_d;
  logic [TS_WIDTH-1:0]    shreg_shift_d;
  logic                   xfer_d;

  generate
    for (genvar gi = 0; gi < NCH; gi++) begin : g_slice
      assign ts_arr[gi] = ts_data[gi*TS_WIDTH +: TS_WIDTH];
    end
  endgenerate

  // Candidate channel k places after base, modulo NCH (k is 1..NCH).
  function automatic logic [CH_W-1:0] wrap_add(input logic [CH_W-1:0] base, input int k);
    int s;
    s = int'(base) + k;
    if (s >= NCH) begin
      s = s - NCH;
    end
    return CH_W'(s);
  endfunction

  // Walk the ring from the farthest candidate to the nearest so the nearest
  // set request after last_grant wins.
  always_comb begin
    grant_vld_d = 1'b0;
    grant_idx_d = '0;
    for (int k = NCH; k >= 1; k--) begin
      if (req[wrap_add(last_grant_q, k)]) begin
        grant_vld_d = 1'b1;
        grant_idx_d = wrap_add(last_grant_q, k);
      end
    end
  end

  assign hdr_ch_d      = 4'(grant_idx_d);
  assign shreg_shift_d = shreg_q << 8;
  assign xfer_d        = tx_valid_q && tx.tx_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      last_grant_q  <= CH_W'(NCH - 1);
      shreg_q       <= '0;
      byte_cnt_q    <= '0;
      tx_data_q     <= 8'h00;
      tx_valid_q    <= 1'b0;
      ack_q         <= '0;
      frame_count_q <= '0;
    end else begin
      ack_q <= '0;
      case (state_q)
        IDLE: begin
          if (enable && grant_vld_d) begin
            shreg_q             <= ts_arr[grant_idx_d];
            last_grant_q        <= grant_idx_d;
            ack_q[grant_idx_d]  <= 1'b1;
            tx_data_q           <= {4'hA, hdr_ch_d};
            tx_valid_q          <= 1'b1;
            state_q             <= HDR;
          end
        end
        HDR: begin
          if (xfer_d) begin
            tx_data_q  <= shreg_q[TS_WIDTH-1 -: 8];
            byte_cnt_q <= BC_W'(NBYTES - 1);
            state_q    <= DATA;
          end
        end
        DATA: begin
          if (xfer_d) begin
            if (byte_cnt_q != '0) begin
              shreg_q    <= shreg_shift_d;
              tx_data_q  <= shreg_shift_d[TS_WIDTH-1 -: 8];
              byte_cnt_q <= byte_cnt_q - BC_W'(1);
            end else begin
              tx_valid_q    <= 1'b0;
              frame_count_q <= frame_count_q + CNT_WIDTH'(1);
              state_q       <= IDLE;
            end
          end
        end
        default: begin
          tx_valid_q <= 1'b0;
          state_q    <= IDLE;
        end
      endcase
    end
  end

  assign ack         = ack_q;
  assign tx.tx_data  = tx_data_q;
  assign tx.tx_valid = tx_valid_q;
  assign busy        = (state_q != IDLE);
  assign frame_count = frame_count_q;

endmodule

// File: tb/tb_ts_tx_arbiter.sv
// Directed bench for ts_tx_arbiter: framing, round-robin order, backpressure,
// mid-frame reset, enable gating and frame counter wrap.
module tb_ts_tx_arbiter;
  localparam int NCH = 4;
  localparam int TSW = 32;
  localparam int CW  = 4;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic                 enable = 1'b1;
  logic [NCH-1:0]       req = '0;
  logic [NCH*TSW-1:0]   ts_data = '0;
  logic [NCH-1:0]       ack;
  logic                 busy;
  logic [CW-1:0]        frame_count;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0]     byte_q[$];
  logic [NCH-1:0] ack_log[$];
  logic           stall_prev = 1'b0;
  logic [7:0]     data_prev = 8'h00;

  ts_tx_arbiter_if tx_if ();

  ts_tx_arbiter #(
    .NCH       (NCH),
    .TS_WIDTH  (TSW),
    .CNT_WIDTH (CW)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .enable      (enable),
    .req         (req),
    .ts_data     (ts_data),
    .ack         (ack),
    .tx          (tx_if.master),
    .busy        (busy),
    .frame_count (frame_count)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Observe the handshake half a cycle before the edge that completes it.
  always @(negedge clk) begin
    if (stall_prev) begin
      check_eq("hold_valid", tx_if.tx_valid, 1'b1);
      check_eq("hold_data", tx_if.tx_data, data_prev);
    end
    stall_prev <= tx_if.tx_valid && !tx_if.tx_ready && !rst;
    data_prev  <= tx_if.tx_data;
    if (tx_if.tx_valid && tx_if.tx_ready && !rst) begin
      byte_q.push_back(tx_if.tx_data);
      $display("t=%0t tx byte 0x%02h", $time, tx_if.tx_data);
    end
    if (ack != '0) begin
      ack_log.push_back(ack);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ts(input int ch, input logic [TSW-1:0] v);
    ts_data[ch*TSW +: TSW] = v;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    byte_q.delete();
    ack_log.delete();
  endtask

  task automatic wait_idle(input string tag);
    for (int i = 0; i < 200; i++) begin
      if (!busy) break;
      tick();
    end
    check_eq(tag, busy, 1'b0);
  endtask

  task automatic check_frame(input string tag, input int base, input int ch, input logic [TSW-1:0] ts);
    logic [TSW-1:0] t;
    t = ts;
    check_eq({tag, "_hdr"}, (byte_q.size() > base) ? byte_q[base] : 8'hXX, {4'hA, 4'(ch)});
    for (int b = 0; b < TSW/8; b++) begin
      check_eq({tag, "_byte"}, (byte_q.size() > base+1+b) ? byte_q[base+1+b] : 8'hXX,
               t[TSW-1 -: 8]);
      t = t << 8;
    end
  endtask

  initial begin
    logic [7:0] exp_b [5];
    int hold [NCH];
    int acks;
    bit started;
    logic [NCH-1:0] ack_or;

    tx_if.tx_ready = 1'b1;
    tick();
    tick();
    rst = 1'b0;

    // Reset state
    check_eq("rst_valid", tx_if.tx_valid, 1'b0);
    check_eq("rst_data", tx_if.tx_data, 8'h00);
    check_eq("rst_ack", ack, 4'b0000);
    check_eq("rst_busy", busy, 1'b0);
    check_eq("rst_count", frame_count, 4'd0);

    // Single ch2 frame, ready held high
    byte_q.delete();
    ack_log.delete();
    set_ts(2, 32'h12345678);
    req = 4'b0100;
    exp_b = '{8'hA2, 8'h12, 8'h34, 8'h56, 8'h78};
    tick();
    for (int i = 0; i < 5; i++) begin
      check_eq("t1_ack", ack, (i == 0) ? 4'b0100 : 4'b0000);
      check_eq("t1_valid", tx_if.tx_valid, 1'b1);
      check_eq("t1_data", tx_if.tx_data, exp_b[i]);
      if (ack[2]) req[2] = 1'b0;
      tick();
    end
    check_eq("t1_valid_end", tx_if.tx_valid, 1'b0);
    check_eq("t1_count", frame_count, 4'd1);
    check_eq("t1_busy_end", busy, 1'b0);

    // All four requesting; each drops on ack and re-raises 2 cycles later
    do_reset();
    for (int c = 0; c < NCH; c++) begin
      set_ts(c, 32'h01020304 + 32'h10101010 * c);
      hold[c] = 0;
    end
    req = 4'b1111;
    acks = 0;
    for (int i = 0; i < 300 && acks < 6; i++) begin
      tick();
      for (int c = 0; c < NCH; c++) begin
        if (ack[c]) begin
          req[c]  = 1'b0;
          hold[c] = 2;
          acks++;
        end else if (hold[c] > 0) begin
          hold[c]--;
          if (hold[c] == 0) req[c] = 1'b1;
        end
      end
    end
    req = '0;
    wait_idle("t2_idle");
    check_eq("t2_ack_count", ack_log.size(), 6);
    check_eq("t2_byte_count", byte_q.size(), 30);
    for (int f = 0; f < 6; f++) begin
      check_eq("t2_ack_onehot", (ack_log.size() > f) ? ack_log[f] : 4'hX, 4'b0001 << (f % 4));
      check_eq("t2_hdr", (byte_q.size() > 5*f) ? byte_q[5*f] : 8'hXX, 8'hA0 | 8'(f % 4));
    end
    check_frame("t2_f3", 15, 3, 32'h31323334);
    check_eq("t2_count", frame_count, 4'd6);

    // Channels 1 and 3 held continuously
    do_reset();
    req = 4'b1010;
    acks = 0;
    for (int i = 0; i < 200 && acks < 4; i++) begin
      tick();
      if (ack != '0) acks++;
    end
    req = '0;
    wait_idle("t3_idle");
    ack_or = '0;
    foreach (ack_log[i]) ack_or = ack_or | ack_log[i];
    check_eq("t3_no_ch0_ch2", ack_or & 4'b0101, 4'b0000);
    check_eq("t3_ack_count", ack_log.size(), 4);
    for (int f = 0; f < 4; f++) begin
      check_eq("t3_hdr", (byte_q.size() > 5*f) ? byte_q[5*f] : 8'hXX, (f % 2 == 0) ? 8'hA1 : 8'hA3);
    end

    // Random backpressure on a ch0 frame
    byte_q.delete();
    ack_log.delete();
    set_ts(0, 32'hDEADBEEF);
    req = 4'b0001;
    started = 1'b0;
    for (int i = 0; i < 400; i++) begin
      tick();
      tx_if.tx_ready = 1'($urandom_range(0, 1));
      if (ack[0]) req[0] = 1'b0;
      if (busy) started = 1'b1;
      if (started && !busy) break;
    end
    tx_if.tx_ready = 1'b1;
    check_eq("t4_done", busy, 1'b0);
    check_eq("t4_len", byte_q.size(), 5);
    check_frame("t4", 0, 0, 32'hDEADBEEF);

    // Reset after the second accepted byte of a ch3 frame
    do_reset();
    set_ts(3, 32'hCAFEF00D);
    req = 4'b1000;
    for (int i = 0; i < 50 && byte_q.size() < 2; i++) begin
      tick();
    end
    check_eq("t5_two_bytes", byte_q.size(), 2);
    rst = 1'b1;
    tick();
    check_eq("t5_rst_valid", tx_if.tx_valid, 1'b0);
    check_eq("t5_rst_busy", busy, 1'b0);
    check_eq("t5_rst_count", frame_count, 4'd0);
    check_eq("t5_rst_ack", ack, 4'b0000);
    rst = 1'b0;
    byte_q.delete();
    ack_log.delete();
    for (int i = 0; i < 20 && !ack[3]; i++) begin
      tick();
    end
    check_eq("t5_regrant", ack, 4'b1000);
    check_eq("t5_hdr_now", tx_if.tx_data, 8'hA3);
    req = '0;
    wait_idle("t5_idle");
    check_eq("t5_len", byte_q.size(), 5);
    check_frame("t5", 0, 3, 32'hCAFEF00D);
    check_eq("t5_count", frame_count, 4'd1);

    // Enable gating, then enable dropped mid-frame
    do_reset();
    enable = 1'b0;
    req = 4'b0001;
    for (int i = 0; i < 20; i++) begin
      tick();
      check_eq("t6_gated_ack", ack, 4'b0000);
    end
    check_eq("t6_gated_busy", busy, 1'b0);
    enable = 1'b1;
    for (int i = 0; i < 10 && !ack[0]; i++) begin
      tick();
    end
    check_eq("t6_ack", ack, 4'b0001);
    req = '0;
    enable = 1'b0;
    wait_idle("t6_idle");
    check_eq("t6_len", byte_q.size(), 5);
    check_frame("t6", 0, 0, 32'hDEADBEEF);
    check_eq("t6_count", frame_count, 4'd1);
    enable = 1'b1;

    // Counter wrap with CNT_WIDTH=4
    do_reset();
    req = 4'b0001;
    acks = 0;
    for (int i = 0; i < 400 && acks < 16; i++) begin
      tick();
      if (ack[0]) begin
        acks++;
        if (acks == 16) begin
          check_eq("t7_count_15", frame_count, 4'd15);
          req = '0;
        end
      end
    end
    req = '0;
    wait_idle("t7_idle");
    check_eq("t7_acks", acks, 16);
    check_eq("t7_wrap", frame_count, 4'd0);
    check_eq("t7_bytes", byte_q.size(), 80);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/ts_tx_arbiter.md
Name: ts_tx_arbiter

Overview:
- Shares the single serial output path between the NCH timestamp channels.
- Each channel's capture logic presents a completed timestamp and holds a request.
- The block grants channels round-robin, captures the winning timestamp, and emits one framed byte sequence to the UART transmitter over a valid/ready byte handshake.
- It sits inside the system level, between the per-channel timestamp capture units and the serial transmitter, in the 100 MHz core clock domain.

Parameters:
- NCH, 4, number of requesting channels (2..16).
- TS_WIDTH, 32, timestamp width in bits. Must be a multiple of 8, range 8..64.
- CNT_WIDTH, 16, width of the sent-frame counter.

Ports:
- clk  input  1  core clock; single clock domain.
- rst  input  1  synchronous reset, active-high.
- enable  input  1  when 0, no new grants are issued. A frame already in progress completes.
- req  input  NCH  per-channel request. Held high, with data stable, until the matching ack.
- ts_data  input  NCH*TS_WIDTH  flattened timestamps; channel i occupies bits [i*TS_WIDTH +: TS_WIDTH].
- ack  output  NCH  one-cycle pulse to the channel whose timestamp was captured.
- tx_data  output  8  byte to the transmitter.
- tx_valid  output  1  tx_data is valid.
- tx_ready  input  1  transmitter accepts the byte on a cycle where tx_valid and tx_ready are both high.
- busy  output  1  high while a frame is in progress (any state other than IDLE).
- frame_count  output  CNT_WIDTH  number of frames fully sent; wraps.

Behaviour:
- Reset (synchronous, rst=1 at a clk edge) forces:
  - state=IDLE, tx_valid=0, tx_data=0x00, ack=0, busy=0, frame_count=0.
  - Round-robin pointer last_grant=NCH-1, so channel 0 has first priority.
  - Shift register cleared.
- Frame format: header byte {4'hA, ch[3:0]}, then NBYTES=TS_WIDTH/8 timestamp bytes, most significant byte first.
- States: IDLE, HDR, DATA.
- IDLE:
  - If enable=1 and any req bit is set, the winner is the first set req searching last_grant+1, last_grant+2, ... modulo NCH.
  - At that edge: capture the winner's ts_data into the shift register, store ch, set last_grant=ch, register ack[ch]=1 for exactly one cycle, and go to HDR.
  - tx_valid and the header byte are presented in the cycle following the request, the same cycle ack is high.
  - Latency: req seen in IDLE at edge n gives ack and header valid during cycle n+1.
- HDR:
  - tx_valid=1, tx_data=header.
  - On handshake: load tx_data with the top shift-register byte, byte counter=NBYTES-1, go to DATA.
- DATA:
  - tx_valid=1.
  - On handshake with counter>0: shift left by 8, present the next byte, decrement the counter.
  - On handshake with counter=0: tx_valid=0, frame_count+1 (wrap to 0 past all-ones), go to IDLE.
- Back-to-back frames: at least one IDLE cycle between the last data byte and the next header.
  - With tx_ready held at 1, a frame occupies NBYTES+1 transfer cycles plus 1 idle cycle.
- Backpressure: while tx_valid=1 and tx_ready=0, tx_data and tx_valid hold stable. No byte is dropped or duplicated.
- ack is only ever asserted from IDLE. Because a frame lasts at least 2 cycles, a requester that drops req on seeing ack is never captured twice.
- A req deasserted without having received ack is simply not granted. No error is flagged.
- Simultaneous requests: exactly one grant per frame. The pointer advances only on a grant.
- enable falling mid-frame has no effect until the block returns to IDLE.
- Reset mid-frame: the frame is abandoned, tx_valid=0 from the next cycle, and no ack is issued.
  - frame_count does not include the partial frame (it is reset to 0).
  - Pending requests are re-arbitrated from channel 0.
- Non-granted channels see ack=0 at all times.

Test Plan:
- Reset, tx_ready=1, req[2]=1 with ts=0x12345678:
  - ack=4'b0100 for one cycle, one cycle after req.
  - tx bytes A2,12,34,56,78 on 5 consecutive cycles, then tx_valid=0.
  - frame_count=1.
- req=4'b1111 held, each requester dropping req on ack then re-raising 2 cycles later:
  - Grant order 0,1,2,3,0,1.
  - Exactly one ack pulse per frame.
- req[1] and req[3] held continuously (re-raised immediately after ack):
  - Headers A1,A3,A1,A3.
  - Channels 0 and 2 are never acked.
- Random tx_ready (50% duty), channel 0 ts=0xDEADBEEF:
  - tx_data is stable whenever tx_valid=1 and tx_ready=0.
  - Accepted sequence is exactly A0,DE,AD,BE,EF.
- rst pulsed after the 2nd accepted byte of a ch3 frame, req[3] still held:
  - tx_valid=0 and busy=0 the next cycle, frame_count=0.
  - A fresh ch3 frame then starts with header A3 and is sent in full.
- Enable gating and counter wrap:
  - enable=0 with req[0]=1 gives no ack for 20 cycles.
  - enable dropped mid-frame: that frame completes.
  - With CNT_WIDTH=4, 16 frames take frame_count from 15 to 0.
